countdown_timer_ctrl: RTL and testbench

Sequencing controller for the 1 Hz tick source in the clock/timer path. It gates and phase-aligns the tick divider, holds a BCD minutes:seconds countdown value set by buttons, and decrements it once per tick. At 00:00 it raises an alarm for a fixed number of ticks, then returns to idle. Display drivers consume its outputs directly.

---
 rtl/countdown_timer_ctrl.sv | 162 ++++++++++++++++
 tb/tb_countdown_timer_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_ctrl.sv
// rtl/countdown_timer_ctrl.sv - BCD mm:ss countdown sequencer driving the 1 Hz tick divider
module countdown_timer_ctrl #(
    parameter int MAX_MIN   = 59,
    parameter int ALARM_SEC = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_min,
    input  logic       btn_sec,
    output logic       div_run,
    output logic       div_clr,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       alarm
);

    localparam int              CW          = $clog2(ALARM_SEC + 1);
    localparam logic [7:0]      MAX_MIN_BCD = 8'(((MAX_MIN / 10) * 16) + (MAX_MIN % 10));
    localparam logic [CW-1:0]   ALARM_LAST  = CW'(ALARM_SEC);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_ALARM} state_t;

    state_t        state_q, state_d;
    logic [7:0]    min_d, sec_d;
    logic [CW-1:0] acnt_q, acnt_d;
    logic          start_ok;
    logic          div_clr_d, running_d, alarm_d, div_run_d;

    // BCD +1 with wrap to 00 after the top value
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        logic [7:0] r;
        if (v == top)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // BCD -1; callers guarantee a nonzero operand
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0)
            r = {v[7:4] - 4'd1, 4'd9};
        else
            r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    // State, countdown value and alarm counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            min_bcd <= 8'h00;
            sec_bcd <= 8'h00;
            acnt_q  <= '0;
        end else begin
            state_q <= state_d;
            min_bcd <= min_d;
            sec_bcd <= sec_d;
            acnt_q  <= acnt_d;
        end
    end

    // Next state and datapath; clear > start > tick > min/sec, losers discarded
    always_comb begin
        state_d  = state_q;
        min_d    = min_bcd;
        sec_d    = sec_bcd;
        acnt_d   = acnt_q;
        start_ok = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (btn_clear) begin
                    min_d = 8'h00;
                    sec_d = 8'h00;
                end else if (btn_start) begin
                    if (min_bcd != 8'h00 || sec_bcd != 8'h00) begin
                        state_d  = S_RUN;
                        start_ok = 1'b1;
                    end
                end else if (!tick) begin
                    if (btn_min) min_d = bcd_inc(min_bcd, MAX_MIN_BCD);
                    if (btn_sec) sec_d = bcd_inc(sec_bcd, 8'h59);
                end
            end
            S_RUN: begin
                if (btn_clear) begin
                    state_d = S_IDLE;
                    min_d   = 8'h00;
                    sec_d   = 8'h00;
                end else if (btn_start) begin
                    state_d = S_PAUSE;
                end else if (tick) begin
                    if (sec_bcd != 8'h00) begin
                        sec_d = bcd_dec(sec_bcd);
                    end else begin
                        sec_d = 8'h59;
                        min_d = bcd_dec(min_bcd);
                    end
                    if (min_d == 8'h00 && sec_d == 8'h00) begin
                        state_d = S_ALARM;
                        acnt_d  = '0;
                    end
                end
            end
            S_PAUSE: begin
                if (btn_clear) begin
                    state_d = S_IDLE;
                    min_d   = 8'h00;
                    sec_d   = 8'h00;
                end else if (btn_start) begin
                    state_d  = S_RUN;
                    start_ok = 1'b1;
                end
            end
            S_ALARM: begin
                if (btn_clear || btn_start) begin
                    state_d = S_IDLE;
                    acnt_d  = '0;
                end else if (tick) begin
                    if (acnt_q + 1'b1 == ALARM_LAST) begin
                        state_d = S_IDLE;
                        acnt_d  = '0;
                    end else begin
                        acnt_d = acnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so outputs come straight from flops
    always_comb begin
        div_clr_d = start_ok;
        running_d = (state_d == S_RUN);
        alarm_d   = (state_d == S_ALARM);
        div_run_d = running_d | alarm_d;
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_clr <= 1'b0;
            running <= 1'b0;
            alarm   <= 1'b0;
            div_run <= 1'b0;
        end else begin
            div_clr <= div_clr_d;
            running <= running_d;
            alarm   <= alarm_d;
            div_run <= div_run_d;
        end
    end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb/tb_countdown_timer_ctrl.sv - self-checking bench for countdown_timer_ctrl
module tb_countdown_timer_ctrl;

    localparam int MAX_MIN   = 59;
    localparam int ALARM_SEC = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0, btn_start = 1'b0, btn_clear = 1'b0, btn_min = 1'b0, btn_sec = 1'b0;
    logic       div_run, div_clr, running, alarm;
    logic [7:0] min_bcd, sec_bcd;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_ALARM} mstate_e;
    mstate_e m_st = M_IDLE;
    int      m_min = 0, m_sec = 0, m_acnt = 0;
    bit      m_div_clr = 1'b0;

    countdown_timer_ctrl #(.MAX_MIN(MAX_MIN), .ALARM_SEC(ALARM_SEC)) dut (
        .clk(clk), .reset(reset), .tick(tick), .btn_start(btn_start), .btn_clear(btn_clear),
        .btn_min(btn_min), .btn_sec(btn_sec), .div_run(div_run), .div_clr(div_clr),
        .min_bcd(min_bcd), .sec_bcd(sec_bcd), .running(running), .alarm(alarm)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int n);
        return 8'(((n / 10) * 16) + (n % 10));
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_min = 0; m_sec = 0; m_acnt = 0; m_div_clr = 1'b0;
    endtask

    // One clock of the timer's behaviour, in whole minutes/seconds
    task automatic model_step(input bit s, input bit c, input bit t, input bit mi, input bit se);
        int total;
        m_div_clr = 1'b0;
        case (m_st)
            M_IDLE: begin
                if (c) begin m_min = 0; m_sec = 0; end
                else if (s) begin
                    if (m_min * 60 + m_sec > 0) begin m_st = M_RUN; m_div_clr = 1'b1; end
                end else if (!t) begin
                    if (mi) m_min = (m_min == MAX_MIN) ? 0 : m_min + 1;
                    if (se) m_sec = (m_sec == 59) ? 0 : m_sec + 1;
                end
            end
            M_RUN: begin
                if (c) begin m_st = M_IDLE; m_min = 0; m_sec = 0; end
                else if (s) m_st = M_PAUSE;
                else if (t) begin
                    total = m_min * 60 + m_sec - 1;
                    m_min = total / 60;
                    m_sec = total % 60;
                    if (total == 0) begin m_st = M_ALARM; m_acnt = 0; end
                end
            end
            M_PAUSE: begin
                if (c) begin m_st = M_IDLE; m_min = 0; m_sec = 0; end
                else if (s) begin m_st = M_RUN; m_div_clr = 1'b1; end
            end
            M_ALARM: begin
                if (c || s) begin m_st = M_IDLE; m_acnt = 0; end
                else if (t) begin
                    m_acnt++;
                    if (m_acnt == ALARM_SEC) begin m_st = M_IDLE; m_acnt = 0; end
                end
            end
            default: m_st = M_IDLE;
        endcase
    endtask

    // Compare every output against the model once per cycle
    always @(negedge clk) begin
        if (check_en) begin
            check("min_bcd", min_bcd, to_bcd(m_min));
            check("sec_bcd", sec_bcd, to_bcd(m_sec));
            check("running", {7'd0, running}, {7'd0, m_st == M_RUN});
            check("alarm",   {7'd0, alarm},   {7'd0, m_st == M_ALARM});
            check("div_run", {7'd0, div_run}, {7'd0, (m_st == M_RUN) || (m_st == M_ALARM)});
            check("div_clr", {7'd0, div_clr}, {7'd0, m_div_clr});
        end
    end

    task automatic cycle(input bit s, input bit c, input bit t, input bit mi, input bit se);
        btn_start = s; btn_clear = c; tick = t; btn_min = mi; btn_sec = se;
        @(posedge clk);
        #1;
        if (!reset) model_step(s, c, t, mi, se);
        btn_start = 1'b0; btn_clear = 1'b0; tick = 1'b0; btn_min = 1'b0; btn_sec = 1'b0;
    endtask

    task automatic press_min(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 1, 0);
    endtask
    task automatic press_sec(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 1);
    endtask
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 1, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_min", min_bcd, 8'h00);
        check("reset_sec", sec_bcd, 8'h00);
        check("reset_run", {7'd0, running}, 8'h00);
        #1 reset = 1'b0;
        check_en = 1'b1;

        // load 03:05 and start
        press_min(3);
        press_sec(5);
        cycle(1, 0, 0, 0, 0);
        check("load_min", min_bcd, 8'h03);
        check("load_sec", sec_bcd, 8'h05);
        check("start_running", {7'd0, running}, 8'h01);
        check("start_div_clr", {7'd0, div_clr}, 8'h01);
        cycle(0, 0, 0, 0, 0);
        check("div_clr_one_cycle", {7'd0, div_clr}, 8'h00);
        cycle(0, 1, 0, 0, 0);

        // 01:00 countdown into alarm
        press_min(1);
        cycle(1, 0, 0, 0, 0);
        ticks(1);
        check("dec_min", min_bcd, 8'h00);
        check("dec_sec", sec_bcd, 8'h59);
        ticks(59);
        check("reach_alarm", {7'd0, alarm}, 8'h01);
        check("alarm_div_run", {7'd0, div_run}, 8'h01);
        check("alarm_not_running", {7'd0, running}, 8'h00);
        ticks(ALARM_SEC - 1);
        check("alarm_held", {7'd0, alarm}, 8'h01);
        ticks(1);
        check("alarm_done", {7'd0, alarm}, 8'h00);
        check("alarm_done_div_run", {7'd0, div_run}, 8'h00);

        // alarm cut short by start
        press_sec(1);
        cycle(1, 0, 0, 0, 0);
        ticks(1);
        check("alarm2", {7'd0, alarm}, 8'h01);
        ticks(3);
        cycle(1, 0, 0, 0, 0);
        check("alarm_abort", {7'd0, alarm}, 8'h00);

        // pause with coincident tick
        press_sec(5);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 0);
        check("pause_sec", sec_bcd, 8'h05);
        check("pause_running", {7'd0, running}, 8'h00);
        ticks(3);
        check("pause_hold", sec_bcd, 8'h05);
        cycle(1, 0, 0, 0, 0);
        check("resume_running", {7'd0, running}, 8'h01);
        check("resume_div_clr", {7'd0, div_clr}, 8'h01);

        // start at zero, wraps
        cycle(0, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        check("zero_start_running", {7'd0, running}, 8'h00);
        check("zero_start_div_clr", {7'd0, div_clr}, 8'h00);
        press_sec(59);
        check("sec_59", sec_bcd, 8'h59);
        press_sec(1);
        check("sec_wrap", sec_bcd, 8'h00);
        press_min(MAX_MIN);
        check("min_max", min_bcd, 8'h59);
        press_min(1);
        check("min_wrap", min_bcd, 8'h00);

        // async reset mid-run at 02:17
        press_min(2);
        press_sec(17);
        cycle(1, 0, 0, 0, 0);
        check("run_0217_min", min_bcd, 8'h02);
        check("run_0217_sec", sec_bcd, 8'h17);
        #2 reset = 1'b1;
        #1;
        check("areset_min", min_bcd, 8'h00);
        check("areset_sec", sec_bcd, 8'h17 & 8'h00);
        check("areset_running", {7'd0, running}, 8'h00);
        check("areset_div_run", {7'd0, div_run}, 8'h00);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b0;

        // clear beats start in RUN
        press_sec(3);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        check("clr_start_sec", sec_bcd, 8'h00);
        check("clr_start_running", {7'd0, running}, 8'h00);

        // randomized traffic against the model
        for (int i = 0; i < 6000; i++) begin
            cycle($urandom_range(0, 24) == 0, $urandom_range(0, 99) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 4) == 0);
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
